// File: rtl/seq_div16_8_if.sv
// Handshake and operand/result bundle for the seq_div16_8 divider.
// The master drives operands and out_ready; the slave (divider) drives results.
interface seq_div16_8_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_by_zero;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_div16_8.sv
// Sequential radix-2 restoring divider, 16-bit / 8-bit, one quotient bit per clock.
// SEQ_DIV_EARLY_TERM_EN starts iterating at the dividend's leading one instead of bit 15.
module seq_div16_8 (
    input  logic         clk,
    input  logic         rst_n,
    seq_div16_8_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_cnt,   w_cnt_nxt;
    logic [15:0] r_dvd,   w_dvd_nxt;
    logic [7:0]  r_dvs,   w_dvs_nxt;
    logic [7:0]  r_rem,   w_rem_nxt;
    logic [15:0] r_quot,  w_quot_nxt;
    logic        r_dbz,   w_dbz_nxt;

    logic [8:0]  w_trial;
    logic [8:0]  w_diff;
    logic [3:0]  w_start_cnt;
    logic        w_start_zero;

`ifdef SEQ_DIV_EARLY_TERM_EN
    // Leading-one index; bits above it would only shift zeros into the remainder.
    always_comb begin
        w_start_cnt = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (bus.dividend[i]) w_start_cnt = 4'(i);
        end
        w_start_zero = (bus.dividend == '0);
    end
`else
    assign w_start_cnt  = 4'd15;
    assign w_start_zero = 1'b0;
`endif

    assign w_trial = {r_rem, r_dvd[r_cnt]};
    assign w_diff  = w_trial - {1'b0, r_dvs};

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_dvd_nxt   = r_dvd;
        w_dvs_nxt   = r_dvs;
        w_rem_nxt   = r_rem;
        w_quot_nxt  = r_quot;
        w_dbz_nxt   = r_dbz;
        case (r_state)
            IDLE: begin
                if (bus.in_valid) begin
                    w_dvd_nxt  = bus.dividend;
                    w_dvs_nxt  = bus.divisor;
                    w_rem_nxt  = '0;
                    w_quot_nxt = '0;
                    w_dbz_nxt  = 1'b0;
                    if (bus.divisor == '0) begin
                        w_state_nxt = DONE;
                        w_quot_nxt  = '1;
                        w_rem_nxt   = bus.dividend[7:0];
                        w_dbz_nxt   = 1'b1;
                    end else if (w_start_zero) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_state_nxt = BUSY;
                        w_cnt_nxt   = w_start_cnt;
                    end
                end
            end
            BUSY: begin
                if (w_trial >= {1'b0, r_dvs}) begin
                    w_rem_nxt         = w_diff[7:0];
                    w_quot_nxt[r_cnt] = 1'b1;
                end else begin
                    w_rem_nxt = w_trial[7:0];
                end
                if (r_cnt == '0) w_state_nxt = DONE;
                else             w_cnt_nxt   = r_cnt - 4'd1;
            end
            DONE: begin
                if (bus.out_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_dvd  <= '0;
            r_dvs  <= '0;
            r_rem  <= '0;
            r_quot <= '0;
            r_dbz  <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_dvd  <= w_dvd_nxt;
            r_dvs  <= w_dvs_nxt;
            r_rem  <= w_rem_nxt;
            r_quot <= w_quot_nxt;
            r_dbz  <= w_dbz_nxt;
        end
    end

    assign bus.in_ready    = (r_state == IDLE);
    assign bus.out_valid   = (r_state == DONE);
    assign bus.quotient    = r_quot;
    assign bus.remainder   = r_rem;
    assign bus.div_by_zero = r_dbz;
endmodule
